// File: rtl/dm_byte_responder_pkg.sv
// Shared types and helpers for the data-memory byte responder.
package dm_byte_responder_pkg;

  // Wait-state counter width; bounds WAIT_CYCLES to 0..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_WAIT = 2'd1,
    RESP_DONE = 2'd2
  } resp_state_e;

  // LB result: sign-extend the addressed byte to a full word.
  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Byte-addressed data store: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module dm_byte_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [7:0]            i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [7:0]            o_rdata
);

  logic [7:0] r_mem [2**ADDR_WIDTH];

  // Store port: one byte per enabled clock edge.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: combinational lookup.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/dm_byte_responder.sv
// Memory-side responder for the multicycle core's LB/SB strobes: accepts one byte
// access, inserts WAIT_CYCLES wait states, then completes with a one-cycle done pulse.
module dm_byte_responder
  import dm_byte_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] addr,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(WAIT_CYCLES);

  resp_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [7:0]       r_wdata, w_wdata_nxt;
  logic             r_op_wr, w_op_wr_nxt;
  logic [31:0]      r_rdata, w_rdata_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic             w_strobe;
  logic             w_finish;
  logic [31:0]      w_tgt_addr;
  logic             w_tgt_wr;
  logic             w_tgt_oor;
  logic             w_we;
  logic [7:0]       w_ram_rdata;

  // Target of the access being completed: the live request when completing straight
  // out of IDLE (zero wait states), otherwise the latched one.
  always_comb begin
    w_strobe   = dm_read | dm_write;
    w_tgt_addr = (r_state == RESP_IDLE) ? addr : r_addr;
    w_tgt_wr   = (r_state == RESP_IDLE) ? dm_write : r_op_wr;
    w_tgt_oor  = |w_tgt_addr[31:ADDR_WIDTH];
    w_we       = (r_state == RESP_DONE) && r_op_wr && !w_tgt_oor;
  end

  dm_byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_addr[ADDR_WIDTH-1:0]),
    .i_wdata (r_wdata),
    .i_raddr (w_tgt_addr[ADDR_WIDTH-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // Next-state and next-output logic; all outputs are registered from these values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_op_wr_nxt = r_op_wr;
    w_rdata_nxt = r_rdata;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_finish    = 1'b0;

    unique case (r_state)
      RESP_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_strobe) begin
          w_addr_nxt  = addr;
          w_wdata_nxt = wdata;
          w_op_wr_nxt = dm_write;
          w_busy_nxt  = 1'b1;
          w_err_nxt   = dm_read & dm_write;
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = RESP_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_state_nxt = RESP_DONE;
            w_finish    = 1'b1;
          end
        end
      end
      RESP_WAIT: begin
        w_err_nxt = w_strobe;
        if (r_cnt == LP_WAIT) begin
          w_state_nxt = RESP_DONE;
          w_cnt_nxt   = '0;
          w_finish    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RESP_DONE: begin
        // The store itself happens on this edge via the RAM write enable.
        w_err_nxt   = w_strobe;
        w_state_nxt = RESP_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = RESP_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Entering DONE: registered read result and range error appear with done.
    if (w_finish) begin
      w_done_nxt = 1'b1;
      if (w_tgt_oor) w_err_nxt = 1'b1;
      if (!w_tgt_wr) w_rdata_nxt = w_tgt_oor ? '0 : sext8(w_ram_rdata);
    end
  end

  // State, latches and registered outputs; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESP_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_wr <= 1'b0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_op_wr <= w_op_wr_nxt;
      r_rdata <= w_rdata_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Output drive.
  always_comb begin
    rdata = r_rdata;
    busy  = r_busy;
    done  = r_done;
    err   = r_err;
  end

endmodule

// File: tb/tb_dm_byte_responder.sv
// Directed plus randomized checks of two responder builds (2 and 0 wait states)
// against a byte-array reference model.
module tb_dm_byte_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd [2];
  logic        wr [2];
  logic [31:0] a  [2];
  logic [7:0]  d  [2];
  logic [31:0] rdata [2];
  logic        busy [2];
  logic        done [2];
  logic        err  [2];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model per DUT: byte store with written flags, last read result.
  logic [7:0]  mdl_mem   [2][256];
  bit          mdl_valid [2][256];
  logic [31:0] mdl_rd    [2];
  bit          mdl_rd_ok [2];

  always #5 clk = ~clk;

  dm_byte_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(rst_n), .dm_read(rd[0]), .dm_write(wr[0]), .addr(a[0]),
    .wdata(d[0]), .rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  dm_byte_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(rst_n), .dm_read(rd[1]), .dm_write(wr[1]), .addr(a[1]),
    .wdata(d[1]), .rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request. Strobes are raised in the current (idle) cycle; the routine
  // returns in the idle cycle after done so the next call runs back-to-back.
  task automatic do_op(input int unsigned s, input bit wr_e, input bit rd_e,
                       input logic [31:0] ad, input logic [7:0] dt, input bit inject);
    int unsigned w;
    bit oor, both;
    logic [31:0] exp_rd;
    w    = (s == 0) ? 2 : 0;
    oor  = (ad[31:8] != 24'h0);
    both = wr_e && rd_e;
    rd[s] = rd_e; wr[s] = wr_e; a[s] = ad; d[s] = dt;
    tick();
    rd[s] = 1'b0; wr[s] = 1'b0; a[s] = $urandom; d[s] = 8'($urandom);
    for (int unsigned k = 1; k <= w + 1; k++) begin
      chk("busy_op", {31'b0, busy[s]}, 32'd1);
      chk("done_timing", {31'b0, done[s]}, {31'b0, k == w + 1});
      chk("err_pulse", {31'b0, err[s]},
          {31'b0, (k == 1 && both) || (inject && k == 2) || (k == w + 1 && oor)});
      if (k == w + 1) begin
        if (!wr_e) begin
          if (oor) begin
            mdl_rd[s] = '0; mdl_rd_ok[s] = 1'b1;
          end else if (mdl_valid[s][ad[7:0]]) begin
            exp_rd = {{24{mdl_mem[s][ad[7:0]][7]}}, mdl_mem[s][ad[7:0]]};
            mdl_rd[s] = exp_rd; mdl_rd_ok[s] = 1'b1;
          end else begin
            chk("sext_unknown", {8'h0, rdata[s][31:8]}, {8'h0, {24{rdata[s][7]}}});
            mdl_rd_ok[s] = 1'b0;
          end
        end
        if (mdl_rd_ok[s]) chk("rdata_done", rdata[s], mdl_rd[s]);
      end else if (mdl_rd_ok[s]) begin
        chk("rdata_hold", rdata[s], mdl_rd[s]);
      end
      if (inject && k == 1) rd[s] = 1'b1;
      tick();
      rd[s] = 1'b0;
    end
    chk("busy_idle", {31'b0, busy[s]}, 32'd0);
    chk("done_idle", {31'b0, done[s]}, 32'd0);
    chk("err_idle", {31'b0, err[s]}, 32'd0);
    if (mdl_rd_ok[s]) chk("rdata_after", rdata[s], mdl_rd[s]);
    if (wr_e && !oor) begin
      mdl_mem[s][ad[7:0]] = dt;
      mdl_valid[s][ad[7:0]] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rad;
    int unsigned sel;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; a[s] = '0; d[s] = '0;
      mdl_rd[s] = '0; mdl_rd_ok[s] = 1'b1;
      for (int i = 0; i < 256; i++) mdl_valid[s][i] = 1'b0;
    end

    // Reset state.
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_busy", {31'b0, busy[s]}, 32'd0);
      chk("rst_done", {31'b0, done[s]}, 32'd0);
      chk("rst_err", {31'b0, err[s]}, 32'd0);
      chk("rst_rdata", rdata[s], 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // SB then LB, negative byte.
    do_op(0, 1, 0, 32'h10, 8'h85, 0);
    do_op(0, 0, 1, 32'h10, 8'h00, 0);
    chk("t2_rdata", rdata[0], 32'hFFFF_FF85);

    // Reset mid-WAIT: pending write to 0x10 is dropped, no done pulse.
    wr[0] = 1'b1; a[0] = 32'h10; d[0] = 8'h33;
    tick();
    wr[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t1_busy", {31'b0, busy[0]}, 32'd0);
    chk("t1_rdata", rdata[0], 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_no_done", {31'b0, done[0]}, 32'd0);
    end
    rst_n = 1'b1;
    mdl_rd[0] = '0; mdl_rd_ok[0] = 1'b1;
    mdl_rd[1] = '0; mdl_rd_ok[1] = 1'b1;
    tick();
    do_op(0, 0, 1, 32'h10, 8'h00, 0);
    chk("t1_not_stored", rdata[0], 32'hFFFF_FF85);

    // Positive byte at top of range, and an unwritten location.
    do_op(0, 1, 0, 32'hFF, 8'h7F, 0);
    do_op(0, 0, 1, 32'hFF, 8'h00, 0);
    do_op(0, 0, 1, 32'h00, 8'h00, 0);

    // Out of range: no store, read returns zero.
    do_op(0, 1, 0, 32'h100, 8'h55, 0);
    do_op(0, 0, 1, 32'h100, 8'h00, 0);
    do_op(0, 0, 1, 32'h00, 8'h00, 0);

    // Both strobes -> write with err; strobe during WAIT -> err, ignored.
    do_op(0, 1, 1, 32'h20, 8'h9C, 0);
    do_op(0, 0, 1, 32'h20, 8'h00, 1);

    // Zero-wait build, back-to-back.
    do_op(1, 1, 0, 32'h10, 8'h85, 0);
    do_op(1, 0, 1, 32'h10, 8'h00, 0);
    do_op(1, 0, 1, 32'h10, 8'h00, 0);
    do_op(1, 1, 1, 32'h40, 8'hC1, 0);
    do_op(1, 0, 1, 32'h40, 8'h00, 0);
    do_op(1, 0, 1, 32'h1_0040, 8'h00, 0);

    // Randomized traffic on both builds.
    for (int n = 0; n < 300; n++) begin
      for (int unsigned s = 0; s < 2; s++) begin
        if ($urandom_range(0, 7) == 0) rad = $urandom | 32'h100;
        else rad = {24'h0, 8'($urandom)};
        sel = $urandom_range(0, 3);
        do_op(s, sel >= 2, sel != 2, rad, 8'($urandom),
              (s == 0) && ($urandom_range(0, 5) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
